// File: rtl/pingpong_sym_buf_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pingpong_sym_buf_if                                             |
// | Brief    : Write, swap and folded-read handshake bundle for the            |
// |            pingpong_sym_buf. PINGPONG_OVERRUN_CNT_EN adds overrun_count.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface pingpong_sym_buf_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [CNT_W-1:0]  fill_level;
  logic              overrun;
`ifdef PINGPONG_OVERRUN_CNT_EN
  logic [15:0]       overrun_count;
`endif
  logic              swap_req;
  logic              swap_ack;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data_lo;
  logic [DATA_W-1:0] rd_data_hi;
  logic              rd_mid;
  logic              rd_last;

  modport slave (
    input  wr_valid, wr_data, swap_req, rd_ready,
    output
`ifdef PINGPONG_OVERRUN_CNT_EN
           overrun_count,
`endif
           wr_ready, fill_level, overrun, swap_ack,
           rd_valid, rd_data_lo, rd_data_hi, rd_mid, rd_last
  );

  modport master (
    output wr_valid, wr_data, swap_req, rd_ready,
    input
`ifdef PINGPONG_OVERRUN_CNT_EN
           overrun_count,
`endif
           wr_ready, fill_level, overrun, swap_ack,
           rd_valid, rd_data_lo, rd_data_hi, rd_mid, rd_last
  );
endinterface
`default_nettype wire

// File: rtl/pingpong_sym_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pingpong_sym_buf                                                |
// | Brief    : Two-bank ping-pong sample buffer with folded (x[i], x[N-1-i])   |
// |            readout for symmetric FIR. Macro PINGPONG_OVERRUN_CNT_EN adds   |
// |            a saturating dropped-write counter.                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pingpong_sym_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pingpong_sym_buf_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              wsel_q, wsel_d;        // 0: A is the write bank, B is read
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  p_q, p_d;
  logic [CNT_W-1:0]  iss_q, iss_d;
  logic              overrun_q, overrun_d;
  logic              ack_q, ack_d;
  logic              rv_q, rv_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic              mid_q, mid_d;
  logic              last_q, last_d;
`ifdef PINGPONG_OVERRUN_CNT_EN
  logic [15:0]       ocnt_q, ocnt_d;
`endif

  logic [DATA_W-1:0] mem_a_q [DEPTH];
  logic [DATA_W-1:0] mem_b_q [DEPTH];

  logic              w_wr_ready;
  logic              w_wr_fire;
  logic              w_drop;
  logic              w_rd_fire;
  logic              w_load;
  logic              w_swap;
  logic [CNT_W-1:0]  w_n_cap;
  logic [AW-1:0]     w_lo_idx;
  logic [AW-1:0]     w_hi_idx;
  logic [DATA_W-1:0] w_lo_rd;
  logic [DATA_W-1:0] w_hi_rd;

  assign w_wr_ready = (wr_ptr_q != CNT_W'(DEPTH));
  assign w_wr_fire  = bus.wr_valid && w_wr_ready;
  assign w_drop     = bus.wr_valid && !w_wr_ready;
  assign w_rd_fire  = rv_q && bus.rd_ready;
  assign w_load     = (state_q == S_STREAM) && (!rv_q || bus.rd_ready) && (iss_q != p_q);
  // The rd_last handshake edge counts as IDLE so a pending swap is taken with no gap.
  assign w_swap     = bus.swap_req && ((state_q == S_IDLE) || (w_rd_fire && last_q));
  assign w_n_cap    = wr_ptr_q + CNT_W'(w_wr_fire);
  assign w_lo_idx   = iss_q[AW-1:0];
  assign w_hi_idx   = AW'(n_q - CNT_W'(1) - iss_q);
  assign w_lo_rd    = wsel_q ? mem_a_q[w_lo_idx] : mem_b_q[w_lo_idx];
  assign w_hi_rd    = wsel_q ? mem_a_q[w_hi_idx] : mem_b_q[w_hi_idx];

  always_comb begin
    state_d   = state_q;
    wsel_d    = wsel_q;
    wr_ptr_d  = wr_ptr_q;
    n_d       = n_q;
    p_d       = p_q;
    iss_d     = iss_q;
    overrun_d = overrun_q | w_drop;
    ack_d     = 1'b0;
    rv_d      = rv_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    mid_d     = mid_q;
    last_d    = last_q;
`ifdef PINGPONG_OVERRUN_CNT_EN
    ocnt_d    = ocnt_q;
    if (w_drop && (ocnt_q != 16'hFFFF)) begin
      ocnt_d = ocnt_q + 16'd1;
    end
`endif

    if (w_wr_fire) begin
      wr_ptr_d = wr_ptr_q + CNT_W'(1);
    end

    case (state_q)
      S_STREAM: begin
        if (w_load) begin
          lo_d   = w_lo_rd;
          hi_d   = w_hi_rd;
          last_d = (iss_q == p_q - CNT_W'(1));
          mid_d  = n_q[0] && (iss_q == p_q - CNT_W'(1));
          rv_d   = 1'b1;
          iss_d  = iss_q + CNT_W'(1);
        end else if (w_rd_fire) begin
          rv_d = 1'b0;
          if (last_q) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_swap) begin
      wsel_d   = ~wsel_q;
      n_d      = w_n_cap;
      wr_ptr_d = '0;
      ack_d    = 1'b1;
      iss_d    = '0;
      p_d      = (w_n_cap >> 1) + CNT_W'(w_n_cap[0]);
      state_d  = (w_n_cap != '0) ? S_STREAM : S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wsel_q    <= 1'b0;
      wr_ptr_q  <= '0;
      n_q       <= '0;
      p_q       <= '0;
      iss_q     <= '0;
      overrun_q <= 1'b0;
      ack_q     <= 1'b0;
      rv_q      <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      mid_q     <= 1'b0;
      last_q    <= 1'b0;
`ifdef PINGPONG_OVERRUN_CNT_EN
      ocnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wsel_q    <= wsel_d;
      wr_ptr_q  <= wr_ptr_d;
      n_q       <= n_d;
      p_q       <= p_d;
      iss_q     <= iss_d;
      overrun_q <= overrun_d;
      ack_q     <= ack_d;
      rv_q      <= rv_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      mid_q     <= mid_d;
      last_q    <= last_d;
`ifdef PINGPONG_OVERRUN_CNT_EN
      ocnt_q    <= ocnt_d;
`endif
    end
  end

  // Bank storage carries no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      if (wsel_q) begin
        mem_b_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
      end else begin
        mem_a_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
      end
    end
  end

  assign bus.wr_ready   = w_wr_ready;
  assign bus.fill_level = wr_ptr_q;
  assign bus.overrun    = overrun_q;
  assign bus.swap_ack   = ack_q;
  assign bus.rd_valid   = rv_q;
  assign bus.rd_data_lo = lo_q;
  assign bus.rd_data_hi = hi_q;
  assign bus.rd_mid     = mid_q;
  assign bus.rd_last    = last_q;
`ifdef PINGPONG_OVERRUN_CNT_EN
  assign bus.overrun_count = ocnt_q;
`endif

endmodule
`default_nettype wire
